b08_host_sequencer: RTL and testbench
=====================================

# b08_host_sequencer

Host-side driver for the b08 pattern-matcher core. It buffers 8-bit words from an upstream valid/ready source and presents each one on the matcher's `I` bus with a `START` pulse. It waits out the matcher's fixed 8-address ROM scan, then samples the 4-bit `O` result and returns it with the originating word on a valid/ready result port. It sits between the system bus adapter and the b08 core, owning the `START`/`I`/`O` end of that interface.

## Interface

Parameters:
- `DEPTH`, 4: input word FIFO entries; power of two, 2..16.
- `START_HOLD`, 2: cycles `START` is held high per launch; 1..15.
- `SCAN_CYCLES`, 12: cycles with `START` low before `O` is sampled; must cover the matcher scan plus its output update; 1..255.

Ports:
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  FIFO not full.
- `in_word`  in  8  word to match.
- `I`  out  8  registered word driven to the matcher.
- `START`  out  1  registered launch strobe to the matcher.
- `O`  in  4  matcher result bus.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts result.
- `res_data`  out  4  captured `O`.
- `res_word`  out  8  word that produced `res_data`.
- `busy`  out  1  FSM not in IDLE.
- `hit_count`  out  8  saturating count of captured results with `res_data != 0`.

## Operation

- The FIFO has `DEPTH` entries with wrapping read/write pointers and an occupancy counter of `$clog2(DEPTH)+1` bits.
  - A push occurs on `in_valid & in_ready`.
  - A pop occurs only on the IDLE->LOAD transition.
  - A simultaneous push and pop leaves occupancy unchanged; both pointers advance.
  - A push while full is impossible because `in_ready` is 0.
- FSM states: IDLE, LOAD, SCAN, CAPTURE, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head into `I` and into the `res_word` shadow, set `START`=1, load the counter with `START_HOLD`-1, and go to LOAD.
  - LOAD: `START`=1. When the counter reaches 0, set `START`=0, load the counter with `SCAN_CYCLES`-1, and go to SCAN.
  - SCAN: `START`=0. When the counter reaches 0, go to CAPTURE.
  - CAPTURE: register `O` into `res_data`, set `res_valid`=1, and increment `hit_count` (saturating at 255) if `O != 0`. Go to HOLD.
  - HOLD: on `res_valid & res_ready`, clear `res_valid` and go to IDLE. An unacknowledged result stalls the FSM; the FIFO keeps accepting words.
- `I` holds its value until the next launch. It is never changed while `START`=1 or during SCAN.
- `busy` = (state != IDLE).
- `res_data` and `res_word` are stable while `res_valid`=1.
- Reset (asynchronous, any state) sets:
  - FIFO empty; `in_ready`=1.
  - `I`=0, `START`=0, `res_valid`=0, `res_data`=0, `res_word`=0.
  - `hit_count`=0, state IDLE.
  - A launch in progress is abandoned. No result is produced for it and the popped word is lost.

## Timing

- Push accepted at edge t makes the FIFO non-empty at t+1. If the FSM is in IDLE, `START` and the new `I` are high/valid after edge t+1.
- `START` is high for exactly `START_HOLD` cycles, then low for `SCAN_CYCLES` cycles.
- `O` is sampled on the CAPTURE edge. `res_valid` rises 1 + `START_HOLD` + `SCAN_CYCLES` edges after `START` rises: 15 with the default parameters.
- Result handshake: when `res_ready` is already high, HOLD lasts one cycle and the next launch begins one cycle after IDLE is re-entered. Back-to-back launch spacing is `START_HOLD` + `SCAN_CYCLES` + 3 cycles.
- `in_ready` is combinational from occupancy only. It has no dependency on `in_valid`.

## Test plan

- Reset then a single word: push 0xA5 at cycle 5 -> `START` high cycles 7–8 with `I`=0xA5. Model `O`=0x3 from cycle 15 -> `res_valid` at cycle 22 with `res_data`=0x3, `res_word`=0xA5, `hit_count`=1.
- FIFO fill: hold `res_ready`=0 and push 0x01..0x06 (`DEPTH`=4) -> 0x01 launches, 0x02..0x05 are accepted, `in_ready`=0 until the first result is acknowledged, then 0x06 is accepted. Results return in order 0x01..0x06.
- Zero result: model `O`=0x0 -> `res_data`=0, `hit_count` unchanged. Preload `hit_count` at 255 with a nonzero result -> stays 255.
- Simultaneous push and pop: with occupancy 1 in IDLE, push 0x7E on the launch edge -> occupancy stays 1 and the pointers wrap correctly across 9 consecutive words.
- Reset mid-SCAN: assert `reset` for 1 cycle during SCAN -> `START`=0, `I`=0, `res_valid` never rises for that word, `in_ready`=1 and `busy`=0 immediately.
- Parameter sweep: `START_HOLD`=1, `SCAN_CYCLES`=1 -> `res_valid` rises 3 edges after `START` rises and `START` is high for one cycle.

Source files
------------

// File: rtl/b08_host_sequencer_if.sv
// rtl/b08_host_sequencer_if.sv - upstream word, matcher START/I/O and result bundle for b08_host_sequencer
interface b08_host_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_word;
    logic [7:0] I;
    logic       START;
    logic [3:0] O;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [7:0] res_word;
    logic       busy;
    logic [7:0] hit_count;

    modport master (
        input  in_valid, in_word, O, res_ready,
        output in_ready, I, START, res_valid, res_data, res_word, busy, hit_count
    );

    modport slave (
        output in_valid, in_word, O, res_ready,
        input  in_ready, I, START, res_valid, res_data, res_word, busy, hit_count
    );
endinterface

// File: rtl/b08_host_sequencer.sv
// rtl/b08_host_sequencer.sv - FIFO-buffered launcher for the b08 matcher with timed O capture
module b08_host_sequencer #(
    parameter int DEPTH       = 4,
    parameter int START_HOLD  = 2,
    parameter int SCAN_CYCLES = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    b08_host_sequencer_if.master  bus
);
    localparam int         AW          = $clog2(DEPTH);
    localparam logic [AW:0] LP_FULL    = DEPTH[AW:0];
    localparam logic [7:0] LP_HOLD_M1  = 8'(START_HOLD - 1);
    localparam logic [7:0] LP_SCAN_M1  = 8'(SCAN_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_CAPTURE, S_HOLD} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_cnt;
    logic [7:0]    r_i;
    logic          r_start;
    logic          r_res_valid;
    logic [3:0]    r_res_data;
    logic [7:0]    r_res_word;
    logic [7:0]    r_hit_count;
    logic          w_push, w_pop, w_cnt_zero;
    logic [7:0]    w_head;

    assign bus.in_ready  = (r_count != LP_FULL);
    assign bus.I         = r_i;
    assign bus.START     = r_start;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_word  = r_res_word;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.hit_count = r_hit_count;

    assign w_push     = bus.in_valid & bus.in_ready;
    assign w_cnt_zero = (r_cnt == 8'd0);
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD:    if (w_cnt_zero) w_state_nxt = S_SCAN;
            S_SCAN:    if (w_cnt_zero) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_HOLD;
            S_HOLD:    if (r_res_valid & bus.res_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Storage needs no reset: only entries behind r_count are ever read.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.in_word;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cnt       <= 8'd0;
            r_i         <= 8'd0;
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 4'd0;
            r_res_word  <= 8'd0;
            r_hit_count <= 8'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_i        <= w_head;
                        r_res_word <= w_head;
                        r_start    <= 1'b1;
                        r_cnt      <= LP_HOLD_M1;
                    end
                end
                S_LOAD: begin
                    if (w_cnt_zero) begin
                        r_start <= 1'b0;
                        r_cnt   <= LP_SCAN_M1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_SCAN: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - 8'd1;
                end
                S_CAPTURE: begin
                    r_res_data  <= bus.O;
                    r_res_valid <= 1'b1;
                    if ((bus.O != 4'd0) && (r_hit_count != 8'hFF))
                        r_hit_count <= r_hit_count + 8'd1;
                end
                S_HOLD: begin
                    if (bus.res_ready) r_res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_b08_host_sequencer.sv
// tb/tb_b08_host_sequencer.sv - directed self-checking bench for b08_host_sequencer
module tb_b08_host_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   exp_hit = 0;
    logic       o_fixed_en;
    logic [3:0] o_fixed;

    always #5 clock = ~clock;

    b08_host_sequencer_if bif ();
    b08_host_sequencer_if bif1 ();

    b08_host_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    b08_host_sequencer #(.DEPTH(4), .START_HOLD(1), .SCAN_CYCLES(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bif1)
    );

    // Matcher stand-in: fixed result, or the low nibble of the presented word.
    always_comb bif.O = o_fixed_en ? o_fixed : bif.I[3:0];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic run_word(input logic [7:0] w, input logic [3:0] o,
                            output logic [7:0] got_word, output logic [3:0] got_data,
                            output int lat);
        o_fixed_en    = 1'b1;
        o_fixed       = o;
        bif.res_ready = 1'b1;
        bif.in_valid  = 1'b1;
        bif.in_word   = w;
        tick();
        bif.in_valid  = 1'b0;
        lat = -1;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (bif.res_valid) begin
                lat = e;
                break;
            end
        end
        got_word = bif.res_word;
        got_data = bif.res_data;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bif.in_valid = 1'b0; bif.in_word = 8'h00; bif.res_ready = 1'b0;
        bif1.in_valid = 1'b0; bif1.in_word = 8'h00; bif1.res_ready = 1'b0; bif1.O = 4'h0;
        o_fixed_en = 1'b1; o_fixed = 4'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total++; if (bif.in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bif.in_ready); end
        total++; if (bif.START !== 1'b0)      begin bad++; $display("FAIL reset_start got=%0b exp=0", bif.START); end
        total++; if (bif.I !== 8'h00)         begin bad++; $display("FAIL reset_i got=%h exp=00", bif.I); end
        total++; if (bif.res_valid !== 1'b0)  begin bad++; $display("FAIL reset_res_valid got=%0b exp=0", bif.res_valid); end
        total++; if (bif.res_data !== 4'h0)   begin bad++; $display("FAIL reset_res_data got=%h exp=0", bif.res_data); end
        total++; if (bif.res_word !== 8'h00)  begin bad++; $display("FAIL reset_res_word got=%h exp=00", bif.res_word); end
        total++; if (bif.busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%0b exp=0", bif.busy); end
        total++; if (bif.hit_count !== 8'h00) begin bad++; $display("FAIL reset_hit got=%0d exp=0", bif.hit_count); end
    endtask

    task automatic test_single;
        int k;
        o_fixed_en = 1'b1; o_fixed = 4'h3; bif.res_ready = 1'b0;
        bif.in_valid = 1'b1; bif.in_word = 8'hA5;
        tick();
        bif.in_valid = 1'b0;
        total++; if (bif.START !== 1'b0) begin bad++; $display("FAIL single_start_pre got=%0b exp=0", bif.START); end
        tick();
        total++; if (bif.START !== 1'b1) begin bad++; $display("FAIL single_start_rise got=%0b exp=1", bif.START); end
        total++; if (bif.I !== 8'hA5)    begin bad++; $display("FAIL single_i got=%h exp=a5", bif.I); end
        for (k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                total++; if (bif.START !== 1'b1) begin bad++; $display("FAIL single_start_hold got=%0b exp=1", bif.START); end
            end
            if (k == 2) begin
                total++; if (bif.START !== 1'b0) begin bad++; $display("FAIL single_start_fall got=%0b exp=0", bif.START); end
            end
            if (bif.res_valid) break;
        end
        exp_hit = 1;
        total++; if (k != 15)                   begin bad++; $display("FAIL single_latency got=%0d exp=15", k); end
        total++; if (bif.res_data !== 4'h3)     begin bad++; $display("FAIL single_res_data got=%h exp=3", bif.res_data); end
        total++; if (bif.res_word !== 8'hA5)    begin bad++; $display("FAIL single_res_word got=%h exp=a5", bif.res_word); end
        total++; if (bif.I !== 8'hA5)           begin bad++; $display("FAIL single_i_stable got=%h exp=a5", bif.I); end
        total++; if (bif.hit_count !== 8'(exp_hit)) begin bad++; $display("FAIL single_hit got=%0d exp=%0d", bif.hit_count, exp_hit); end
        bif.res_ready = 1'b1;
        tick();
        total++; if (bif.res_valid !== 1'b0) begin bad++; $display("FAIL single_ack got=%0b exp=0", bif.res_valid); end
        total++; if (bif.busy !== 1'b0)      begin bad++; $display("FAIL single_idle got=%0b exp=0", bif.busy); end
    endtask

    task automatic test_fifo_fill;
        int idx = 0;
        int rx = 0;
        logic acc;
        logic stalled = 1'b0;
        logic [7:0] ew;
        o_fixed_en = 1'b0; bif.res_ready = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bif.in_valid = (idx < 6);
            bif.in_word  = 8'(idx + 1);
            if (bif.res_valid && !stalled) begin
                stalled = 1'b1;
                total++; if (idx != 5)             begin bad++; $display("FAIL fill_accepted got=%0d exp=5", idx); end
                total++; if (bif.in_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%0b exp=0", bif.in_ready); end
                bif.res_ready = 1'b1;
            end
            if (bif.res_valid && bif.res_ready) begin
                ew = 8'(rx + 1);
                total++; if (bif.res_word !== ew)      begin bad++; $display("FAIL fill_word got=%h exp=%h", bif.res_word, ew); end
                total++; if (bif.res_data !== ew[3:0]) begin bad++; $display("FAIL fill_data got=%h exp=%h", bif.res_data, ew[3:0]); end
                if (ew[3:0] != 4'h0 && exp_hit < 255) exp_hit++;
                rx++;
            end
            acc = bif.in_valid & bif.in_ready;
            tick();
            if (acc) idx++;
            if (rx == 6) break;
        end
        bif.in_valid = 1'b0;
        total++; if (rx != 6) begin bad++; $display("FAIL fill_results got=%0d exp=6", rx); end
        total++; if (bif.hit_count !== 8'(exp_hit)) begin bad++; $display("FAIL fill_hit got=%0d exp=%0d", bif.hit_count, exp_hit); end
    endtask

    task automatic test_zero_result;
        logic [7:0] gw; logic [3:0] gd; int lat;
        run_word(8'h3C, 4'h0, gw, gd, lat);
        total++; if (lat != 16)     begin bad++; $display("FAIL zero_latency got=%0d exp=16", lat); end
        total++; if (gd !== 4'h0)   begin bad++; $display("FAIL zero_data got=%h exp=0", gd); end
        total++; if (gw !== 8'h3C)  begin bad++; $display("FAIL zero_word got=%h exp=3c", gw); end
        total++; if (bif.hit_count !== 8'(exp_hit)) begin bad++; $display("FAIL zero_hit got=%0d exp=%0d", bif.hit_count, exp_hit); end
    endtask

    task automatic test_simul_push_pop;
        int idx = 0;
        int rx = 0;
        logic acc;
        logic [7:0] ew;
        o_fixed_en = 1'b0; bif.res_ready = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bif.in_valid = !bif.busy && (idx < 9);
            bif.in_word  = 8'h7E + 8'(idx * 17);
            if (bif.in_valid) begin
                total++; if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL simul_ready got=%0b exp=1", bif.in_ready); end
            end
            if (bif.res_valid && bif.res_ready) begin
                ew = 8'h7E + 8'(rx * 17);
                total++; if (bif.res_word !== ew)      begin bad++; $display("FAIL simul_word got=%h exp=%h", bif.res_word, ew); end
                total++; if (bif.res_data !== ew[3:0]) begin bad++; $display("FAIL simul_data got=%h exp=%h", bif.res_data, ew[3:0]); end
                if (ew[3:0] != 4'h0 && exp_hit < 255) exp_hit++;
                rx++;
            end
            acc = bif.in_valid & bif.in_ready;
            tick();
            if (acc) idx++;
            if (rx == 9) break;
        end
        bif.in_valid = 1'b0;
        total++; if (rx != 9) begin bad++; $display("FAIL simul_results got=%0d exp=9", rx); end
        total++; if (bif.hit_count !== 8'(exp_hit)) begin bad++; $display("FAIL simul_hit got=%0d exp=%0d", bif.hit_count, exp_hit); end
    endtask

    task automatic test_saturation;
        logic [7:0] gw; logic [3:0] gd; int lat;
        for (int n = 0; n < 300 && exp_hit < 255; n++) begin
            run_word(8'h5A, 4'h5, gw, gd, lat);
            exp_hit++;
        end
        total++; if (bif.hit_count !== 8'(exp_hit)) begin bad++; $display("FAIL sat_reach got=%0d exp=%0d", bif.hit_count, exp_hit); end
        run_word(8'h6B, 4'h5, gw, gd, lat);
        total++; if (gd !== 4'h5) begin bad++; $display("FAIL sat_data got=%h exp=5", gd); end
        total++; if (bif.hit_count !== 8'hFF) begin bad++; $display("FAIL sat_hold got=%0d exp=255", bif.hit_count); end
    endtask

    task automatic test_reset_mid_scan;
        int rv_cycles = 0;
        int busy_cycles = 0;
        o_fixed_en = 1'b1; o_fixed = 4'h7; bif.res_ready = 1'b0;
        bif.in_valid = 1'b1; bif.in_word = 8'h99;
        tick();
        bif.in_word = 8'h42;
        tick();
        bif.in_valid = 1'b0;
        repeat (5) tick();
        #3 reset = 1'b1;
        #1;
        total++; if (bif.START !== 1'b0)     begin bad++; $display("FAIL mid_start got=%0b exp=0", bif.START); end
        total++; if (bif.I !== 8'h00)        begin bad++; $display("FAIL mid_i got=%h exp=00", bif.I); end
        total++; if (bif.in_ready !== 1'b1)  begin bad++; $display("FAIL mid_in_ready got=%0b exp=1", bif.in_ready); end
        total++; if (bif.busy !== 1'b0)      begin bad++; $display("FAIL mid_busy got=%0b exp=0", bif.busy); end
        total++; if (bif.hit_count !== 8'h0) begin bad++; $display("FAIL mid_hit got=%0d exp=0", bif.hit_count); end
        tick();
        reset = 1'b0;
        exp_hit = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bif.res_valid) rv_cycles++;
            if (bif.busy) busy_cycles++;
        end
        total++; if (rv_cycles != 0)   begin bad++; $display("FAIL mid_no_result got=%0d exp=0", rv_cycles); end
        total++; if (busy_cycles != 0) begin bad++; $display("FAIL mid_no_launch got=%0d exp=0", busy_cycles); end
    endtask

    task automatic test_param_sweep;
        int k;
        bif1.O = 4'h9; bif1.res_ready = 1'b0;
        bif1.in_valid = 1'b1; bif1.in_word = 8'hC3;
        tick();
        bif1.in_valid = 1'b0;
        total++; if (bif1.START !== 1'b0) begin bad++; $display("FAIL sweep_start_pre got=%0b exp=0", bif1.START); end
        tick();
        total++; if (bif1.START !== 1'b1) begin bad++; $display("FAIL sweep_start_rise got=%0b exp=1", bif1.START); end
        total++; if (bif1.I !== 8'hC3)    begin bad++; $display("FAIL sweep_i got=%h exp=c3", bif1.I); end
        for (k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) begin
                total++; if (bif1.START !== 1'b0) begin bad++; $display("FAIL sweep_start_fall got=%0b exp=0", bif1.START); end
            end
            if (bif1.res_valid) break;
        end
        total++; if (k != 3)                begin bad++; $display("FAIL sweep_latency got=%0d exp=3", k); end
        total++; if (bif1.res_data !== 4'h9) begin bad++; $display("FAIL sweep_data got=%h exp=9", bif1.res_data); end
        total++; if (bif1.res_word !== 8'hC3) begin bad++; $display("FAIL sweep_word got=%h exp=c3", bif1.res_word); end
        bif1.res_ready = 1'b1;
        tick();
        total++; if (bif1.res_valid !== 1'b0) begin bad++; $display("FAIL sweep_ack got=%0b exp=0", bif1.res_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fifo_fill();
        test_zero_result();
        test_simul_push_pop();
        test_saturation();
        test_reset_mid_scan();
        test_param_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
